// File: rtl/div_if.sv
// ============================================================================
// Module      : div_if
// Description : Request/response bundle between the EX stage and div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_if;
    logic        start_i;
    logic        annul_i;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    modport master (
        output start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        input  result_o, ready_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_div_i, opdata1_i, opdata2_i,
        output result_o, ready_o, busy_o
    );
endinterface

`default_nettype wire

// File: rtl/div_seq.sv
// ============================================================================
// Module      : div_seq
// Description : 32-bit sequential restoring divider, {remainder, quotient}.
//               Define DIV_SIGNED_EN to honour signed_div_i (signed DIV).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_seq (
    input  wire logic clk,
    input  wire logic rst,
    div_if.slave      bus
);

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BYZERO = 2'd1,
        ON     = 2'd2,
        ENDST  = 2'd3
    } state_t;

    localparam logic [5:0] c_last_step = 6'd32;

    state_t      r_state;
    state_t      w_next;
    logic        w_busy_next;
    logic [5:0]  r_cnt;
    logic [64:0] r_shreg;
    logic [31:0] r_divisor;
    logic [63:0] r_result;
    logic        r_ready;
    logic        r_busy;
    logic        w_accept;

    logic [31:0] w_op1_abs;
    logic [31:0] w_op2_abs;
    logic [31:0] w_quo;
    logic [31:0] w_rem;

    logic [64:0] w_shifted;
    logic [33:0] w_diff;

    assign w_accept = bus.start_i && !bus.annul_i;

`ifdef DIV_SIGNED_EN
    logic r_qneg;
    logic r_rneg;
    logic w_neg1;
    logic w_neg2;

    assign w_neg1    = bus.signed_div_i && bus.opdata1_i[31];
    assign w_neg2    = bus.signed_div_i && bus.opdata2_i[31];
    assign w_op1_abs = w_neg1 ? (~bus.opdata1_i + 32'd1) : bus.opdata1_i;
    assign w_op2_abs = w_neg2 ? (~bus.opdata2_i + 32'd1) : bus.opdata2_i;
    assign w_quo     = r_qneg ? (~r_shreg[31:0] + 32'd1)  : r_shreg[31:0];
    assign w_rem     = r_rneg ? (~r_shreg[63:32] + 32'd1) : r_shreg[63:32];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
        end else if (r_state == FREE && w_accept) begin
            r_qneg <= w_neg1 ^ w_neg2;
            r_rneg <= w_neg1;
        end
    end
`else
    logic w_unused_signed;

    assign w_unused_signed = bus.signed_div_i;
    assign w_op1_abs       = bus.opdata1_i;
    assign w_op2_abs       = bus.opdata2_i;
    assign w_quo           = r_shreg[31:0];
    assign w_rem           = r_shreg[63:32];
`endif

    // One restoring step: shift left, trial-subtract divisor from the upper half.
    assign w_shifted = {r_shreg[63:0], 1'b0};
    assign w_diff    = {1'b0, w_shifted[64:32]} - {2'b00, r_divisor};

    always_comb begin
        w_next      = r_state;
        w_busy_next = 1'b0;
        case (r_state)
            FREE: begin
                if (w_accept)
                    w_next = (bus.opdata2_i == 32'd0) ? BYZERO : ON;
            end
            BYZERO: w_next = bus.annul_i ? FREE : ENDST;
            ON: begin
                if (bus.annul_i)
                    w_next = FREE;
                else if (r_cnt == c_last_step)
                    w_next = ENDST;
            end
            ENDST: begin
                if (bus.annul_i || !bus.start_i)
                    w_next = FREE;
            end
            default: w_next = FREE;
        endcase
        w_busy_next = (w_next == ON) || (w_next == BYZERO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= FREE;
            r_cnt     <= 6'd0;
            r_shreg   <= 65'd0;
            r_divisor <= 32'd0;
            r_result  <= 64'd0;
            r_ready   <= 1'b0;
            r_busy    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_busy  <= w_busy_next;
            case (r_state)
                FREE: begin
                    r_ready  <= 1'b0;
                    r_result <= 64'd0;
                    if (w_accept) begin
                        r_cnt     <= 6'd0;
                        r_shreg   <= {33'd0, w_op1_abs};
                        r_divisor <= w_op2_abs;
                    end
                end
                BYZERO: begin
                    r_ready  <= 1'b0;
                    r_result <= 64'd0;
                end
                ON: begin
                    if (bus.annul_i) begin
                        r_ready  <= 1'b0;
                        r_result <= 64'd0;
                    end else if (r_cnt != c_last_step) begin
                        r_shreg <= w_diff[33] ? w_shifted
                                              : {w_diff[32:0], w_shifted[31:1], 1'b1};
                        r_cnt   <= r_cnt + 6'd1;
                    end else begin
                        r_result <= {w_rem, w_quo};
                    end
                end
                ENDST: begin
                    // ready rises one cycle after entering END and holds until start drops.
                    if (bus.annul_i || !bus.start_i) begin
                        r_ready  <= 1'b0;
                        r_result <= 64'd0;
                    end else begin
                        r_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_ready  <= 1'b0;
                    r_result <= 64'd0;
                end
            endcase
        end
    end

    assign bus.result_o = r_result;
    assign bus.ready_o  = r_ready;
    assign bus.busy_o   = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_div_seq.sv
// ============================================================================
// Module      : tb_div_seq
// Description : Directed self-checking bench for div_seq.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_seq;

    logic clk;
    logic rst;
    int   nvec;
    int   nerr;

    div_if bus ();

    div_seq u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a divide and wait for ready; lat = edges from accept to ready (0 on timeout).
    task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                           output int lat, output int busyc);
        bus.start_i      = 1'b1;
        bus.opdata1_i    = a;
        bus.opdata2_i    = b;
        bus.signed_div_i = s;
        lat   = 0;
        busyc = 0;
        tick();
        bus.opdata1_i    = 32'h5A5A_1234;
        bus.opdata2_i    = 32'h0000_0003;
        bus.signed_div_i = ~s;
        busyc += int'(bus.busy_o);
        for (int i = 1; i <= 60; i++) begin
            tick();
            busyc += int'(bus.busy_o);
            if (bus.ready_o) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic end_div();
        bus.start_i = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        nvec++;
        if (bus.result_o !== 64'd0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            nerr++;
            $display("FAIL reset: result=%h ready=%b busy=%b, required 0/0/0",
                     bus.result_o, bus.ready_o, bus.busy_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_unsigned();
        int lat, busyc;
        run_div(32'd100, 32'd7, 1'b0, lat, busyc);
        nvec++;
        if (lat !== 34) begin
            nerr++; $display("FAIL u100_7_latency: got %0d, required 34", lat);
        end
        nvec++;
        if (busyc !== 33) begin
            nerr++; $display("FAIL u100_7_busy_cycles: got %0d, required 33", busyc);
        end
        nvec++;
        if (bus.result_o !== 64'h00000002_0000000E) begin
            nerr++; $display("FAIL u100_7_result: got %h, required 000000020000000e", bus.result_o);
        end
        end_div();
        nvec++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            nerr++; $display("FAIL u100_7_release: ready=%b result=%h, required 0/0",
                             bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_signed();
        int lat, busyc;
        logic [63:0] exp_a, exp_b;
`ifdef DIV_SIGNED_EN
        exp_a = 64'hFFFFFFFF_FFFFFFFD;
        exp_b = 64'h00000000_80000000;
`else
        exp_a = 64'h00000001_7FFFFFFC;
        exp_b = 64'h80000000_00000000;
`endif
        run_div(32'hFFFF_FFF9, 32'd2, 1'b1, lat, busyc);
        nvec++;
        if (bus.result_o !== exp_a) begin
            nerr++; $display("FAIL s_m7_2_result: got %h, required %h", bus.result_o, exp_a);
        end
        nvec++;
        if (lat !== 34) begin
            nerr++; $display("FAIL s_m7_2_latency: got %0d, required 34", lat);
        end
        end_div();
        run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, lat, busyc);
        nvec++;
        if (bus.result_o !== exp_b) begin
            nerr++; $display("FAIL s_overflow_result: got %h, required %h", bus.result_o, exp_b);
        end
        end_div();
    endtask

    task automatic test_divzero();
        int lat, busyc;
        run_div(32'd5, 32'd0, 1'b0, lat, busyc);
        nvec++;
        if (lat !== 2) begin
            nerr++; $display("FAIL div0_latency: got %0d, required 2", lat);
        end
        nvec++;
        if (busyc !== 1) begin
            nerr++; $display("FAIL div0_busy_cycles: got %0d, required 1", busyc);
        end
        nvec++;
        if (bus.result_o !== 64'd0) begin
            nerr++; $display("FAIL div0_result: got %h, required 0", bus.result_o);
        end
        end_div();
    endtask

    task automatic test_annul();
        int lat, busyc;
        logic seen;
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd100;
        bus.opdata2_i = 32'd7;
        tick();
        repeat (9) tick();
        bus.annul_i = 1'b1;
        bus.start_i = 1'b0;
        tick();
        bus.annul_i = 1'b0;
        nvec++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            nerr++; $display("FAIL annul_flush: busy=%b ready=%b result=%h, required 0/0/0",
                             bus.busy_o, bus.ready_o, bus.result_o);
        end
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.ready_o) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++; $display("FAIL annul_no_ready: ready seen=%b, required 0", seen);
        end
        run_div(32'd9, 32'd3, 1'b0, lat, busyc);
        nvec++;
        if (bus.result_o !== 64'h00000000_00000003) begin
            nerr++; $display("FAIL annul_then_9_3: got %h, required 0000000000000003", bus.result_o);
        end
        end_div();
    endtask

    task automatic test_hold();
        int lat, busyc;
        run_div(32'd1000, 32'd33, 1'b0, lat, busyc);
        for (int i = 0; i < 5; i++) begin
            tick();
            nvec++;
            if (bus.ready_o !== 1'b1 || bus.busy_o !== 1'b0 ||
                bus.result_o !== 64'h0000000A_0000001E) begin
                nerr++; $display("FAIL hold_end_%0d: ready=%b busy=%b result=%h, required 1/0/0000000a0000001e",
                                 i, bus.ready_o, bus.busy_o, bus.result_o);
            end
        end
        end_div();
        nvec++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            nerr++; $display("FAIL hold_release: ready=%b result=%h, required 0/0",
                             bus.ready_o, bus.result_o);
        end
    endtask

    task automatic test_reset_mid();
        logic seen;
        bus.start_i   = 1'b1;
        bus.opdata1_i = 32'd12345;
        bus.opdata2_i = 32'd11;
        tick();
        repeat (20) tick();
        rst         = 1'b1;
        bus.start_i = 1'b0;
        tick();
        nvec++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.result_o !== 64'd0) begin
            nerr++; $display("FAIL reset_mid: busy=%b ready=%b result=%h, required 0/0/0",
                             bus.busy_o, bus.ready_o, bus.result_o);
        end
        rst  = 1'b0;
        seen = 1'b0;
        repeat (40) begin
            tick();
            if (bus.ready_o || bus.busy_o) seen = 1'b1;
        end
        nvec++;
        if (seen !== 1'b0) begin
            nerr++; $display("FAIL reset_mid_quiet: activity seen=%b, required 0", seen);
        end
    endtask

    task automatic test_back_to_back();
        int lat, busyc;
        run_div(32'hFFFF_FFFF, 32'd1, 1'b0, lat, busyc);
        nvec++;
        if (bus.result_o !== 64'h00000000_FFFFFFFF) begin
            nerr++; $display("FAIL b2b_max_1: got %h, required 00000000ffffffff", bus.result_o);
        end
        end_div();
        run_div(32'd7, 32'd9, 1'b0, lat, busyc);
        nvec++;
        if (bus.result_o !== 64'h00000007_00000000 || lat !== 34) begin
            nerr++; $display("FAIL b2b_7_9: got %h lat %0d, required 0000000700000000 lat 34",
                             bus.result_o, lat);
        end
        end_div();
    endtask

    initial begin
        nvec             = 0;
        nerr             = 0;
        rst              = 1'b1;
        bus.start_i      = 1'b0;
        bus.annul_i      = 1'b0;
        bus.signed_div_i = 1'b0;
        bus.opdata1_i    = 32'd0;
        bus.opdata2_i    = 32'd0;
        test_reset();
        test_unsigned();
        test_signed();
        test_divzero();
        test_annul();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

`default_nettype wire
